// File: rtl/srambank_pkg.sv
// Shared widths and request types for the srambank_128x4x80 controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package srambank_pkg;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 80;
    localparam int SRAM_WORDS = 512;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
    } req_t;

endpackage

// File: rtl/srambank_rsp_fifo.sv
// Circular response FIFO; head entry drives the output directly from a register.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: caller must never push when full without a same-cycle pop (asserted).
module srambank_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 80
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_vld,
    output logic [WIDTH-1:0]             head_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count    = cnt_q;
    assign head_vld = (cnt_q != '0);
    assign head_dat = mem_q[rd_ptr_q];

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/srambank_ctrl_128x4x80.sv
// Request-to-bank controller for srambank_128x4x80; optional power-up zero fill under SRAM_CTRL_INIT_EN.
// Latency: bank strobes in the accept cycle; read data at rsp 2 cycles after read accept.
// Backpressure: req_ready drops once pending reads plus buffered responses reach RSP_DEPTH.
module srambank_ctrl_128x4x80 #(
    parameter int ADDR_W    = srambank_pkg::ADDR_W,
    parameter int DATA_W    = srambank_pkg::DATA_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_wd,
    output logic              sram_banksel,
    output logic              sram_read,
    output logic              sram_write,
`ifdef SRAM_CTRL_INIT_EN
    output logic              init_done,
`endif
    input  logic [DATA_W-1:0] sram_dataout
);
    import srambank_pkg::*;

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    req_t             req;
    logic             accept;
    logic             pop;
    logic             init_busy;
    logic             rd_pending_q, rd_pending_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight;

    assign req = '{write: req_write, addr: req_addr, wdata: req_wdata};

`ifdef SRAM_CTRL_INIT_EN
    // MSB of the counter set means every word has been written.
    logic [ADDR_W:0] init_cnt_q, init_cnt_d;

    assign init_busy  = !init_cnt_q[ADDR_W];
    assign init_done  = init_cnt_q[ADDR_W];
    assign init_cnt_d = init_busy ? init_cnt_q + 1'b1 : init_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end
`else
    assign init_busy = 1'b0;
`endif

    // A same-cycle pop frees a slot immediately, so reads stream at full rate.
    assign pop       = rsp_valid & rsp_ready;
    assign inflight  = (CNT_W+1)'(rd_pending_q) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop);
    assign req_ready = rst_n & !init_busy & (inflight < (CNT_W+1)'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;

    assign rd_pending_d = accept & !req.write;

    always_comb begin
        sram_banksel = accept;
        sram_write   = accept & req.write;
        sram_read    = accept & !req.write;
        sram_address = req.addr;
        sram_wd      = req.wdata;
`ifdef SRAM_CTRL_INIT_EN
        if (init_busy && rst_n) begin
            sram_banksel = 1'b1;
            sram_write   = 1'b1;
            sram_read    = 1'b0;
            sram_address = init_cnt_q[ADDR_W-1:0];
            sram_wd      = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= rd_pending_d;
        end
    end

    // The bank holds dataout across writes, so capture is safe the cycle after a read.
    srambank_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_pending_q),
        .push_dat (sram_dataout),
        .pop      (pop),
        .count    (fifo_count),
        .head_vld (rsp_valid),
        .head_dat (rsp_rdata)
    );

endmodule

// File: tb/tb_srambank_ctrl_128x4x80.sv
// Directed bench for srambank_ctrl_128x4x80 with a behavioural bank and a response scoreboard.
// Also exercises the zero-fill sequencer when built with SRAM_CTRL_INIT_EN.
module tb_srambank_ctrl_128x4x80;
    import srambank_pkg::*;

    logic  clk, rst_n;
    logic  req_valid, req_ready, req_write;
    addr_t req_addr;
    data_t req_wdata;
    logic  rsp_valid, rsp_ready;
    data_t rsp_rdata;
    addr_t sram_address;
    data_t sram_wd, sram_dataout;
    logic  sram_banksel, sram_read, sram_write;
`ifdef SRAM_CTRL_INIT_EN
    logic  init_done;
`endif

    srambank_ctrl_128x4x80 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .sram_address (sram_address),
        .sram_wd      (sram_wd),
        .sram_banksel (sram_banksel),
        .sram_read    (sram_read),
        .sram_write   (sram_write),
`ifdef SRAM_CTRL_INIT_EN
        .init_done    (init_done),
`endif
        .sram_dataout (sram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank: synchronous write, read data latched and held otherwise.
    data_t bank_mem [SRAM_WORDS];
    data_t bank_dout;
    always @(posedge clk) begin
        if (sram_banksel) begin
            if (sram_write) bank_mem[sram_address] <= sram_wd;
            if (sram_read)  bank_dout <= bank_mem[sram_address];
        end
    end
    assign sram_dataout = bank_dout;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    data_t shadow [SRAM_WORDS];
    data_t exp_q [$];
    int    pop_cyc [$];
    data_t mon_exp;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every handshaken response must match the oldest expected read.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("rsp_data", rsp_rdata, mon_exp);
            pop_cyc.push_back(cyc);
        end
    end

    task automatic issue(input logic wr, input int addr, input data_t wd, input int budget,
                         output bit ok, output int waits);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr_t'(addr);
        req_wdata = wd;
        ok        = 1'b0;
        waits     = 0;
        while (!ok && waits < budget) begin
            @(negedge clk);
            if (req_ready) begin
                chk("strobes", {sram_banksel, sram_write, sram_read, sram_address, sram_wd},
                    {1'b1, wr, !wr, addr_t'(addr), wd});
                ok = 1'b1;
                if (wr) shadow[addr] = wd;
                else    exp_q.push_back(shadow[addr]);
            end else begin
                chk("idle_banksel", sram_banksel, 1'b0);
                waits++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        bit    ok;
        int    w, w_tot, span;
        bit    stale;
        data_t a5;
        a5 = {10{8'hA5}};
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_strobes", {sram_banksel, sram_read, sram_write}, 3'b000);
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef SRAM_CTRL_INIT_EN
        begin
            int  n = 0;
            bit  rdy_seen = 1'b0;
            for (int i = 0; i < SRAM_WORDS; i++) shadow[i] = '0;
            while (n < 600) begin
                @(negedge clk);
                if (init_done) break;
                if (req_ready) rdy_seen = 1'b1;
                n++;
            end
            chk("init_cycles", n, 512);
            chk("init_ready_low", rdy_seen, 1'b0);
            @(posedge clk);
            #1;
            issue(1'b0, 511, '0, 10, ok, w);
            drain("init_read511");
            chk("init_done_held", init_done, 1'b1);
        end
`else
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1'b1);
        @(posedge clk);
        #1;
`endif

        // Write then read addr 3, checking the 2-cycle response latency.
        issue(1'b1, 3, a5, 10, ok, w);
        issue(1'b0, 3, '0, 10, ok, w);
        @(negedge clk);
        chk("t1_valid_n1", rsp_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid_n2", rsp_valid, 1'b1);
        chk("t1_rdata", rsp_rdata, a5);
        @(posedge clk);
        #1;
        drain("t1_drain");

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 8; i++) issue(1'b1, i, {10{8'(8'h10 + i)}} ^ data_t'(i * 977), 10, ok, w);
        pop_cyc.delete();
        w_tot = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, i, '0, 10, ok, w);
            w_tot += w;
        end
        chk("t2_no_stall", w_tot, 0);
        drain("t2_drain");
        span = (pop_cyc.size() == 8) ? pop_cyc[7] - pop_cyc[0] : -1;
        chk("t2_rsp_count", pop_cyc.size(), 8);
        chk("t2_rsp_back2back", span, 7);

        // Credit limit with a stalled client.
        rsp_ready = 1'b0;
        pop_cyc.delete();
        issue(1'b0, 0, '0, 1, ok, w);
        chk("t3_acc0", ok, 1'b1);
        issue(1'b0, 1, '0, 1, ok, w);
        chk("t3_acc1", ok, 1'b1);
        issue(1'b0, 2, '0, 4, ok, w);
        chk("t3_stall", ok, 1'b0);
        @(negedge clk);
        chk("t3_ready_low", req_ready, 1'b0);
        chk("t3_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        issue(1'b0, 2, '0, 2, ok, w);
        chk("t3_acc2", ok, 1'b1);
        issue(1'b0, 3, '0, 2, ok, w);
        chk("t3_acc3", ok, 1'b1);
        drain("t3_drain");
        chk("t3_rsp_count", pop_cyc.size(), 4);

        // Read followed by a write to the same address returns the old data.
        issue(1'b0, 5, '0, 10, ok, w);
        issue(1'b1, 5, {5{16'hC0DE}}, 10, ok, w);
        drain("t4_drain_old");
        issue(1'b0, 5, '0, 10, ok, w);
        drain("t4_drain_new");

        // Reset with one read pending and one response buffered.
        rsp_ready = 1'b0;
        issue(1'b0, 6, '0, 1, ok, w);
        issue(1'b0, 7, '0, 1, ok, w);
        chk("t5_setup", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid_in_rst", rsp_valid, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) stale = 1'b1;
        end
        chk("t5_no_stale", stale, 1'b0);
        @(posedge clk);
        #1;
        issue(1'b0, 6, '0, 600, ok, w);
        chk("t5_recover", ok, 1'b1);
        drain("t5_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/srambank_ctrl_128x4x80.md
Name: srambank_ctrl_128x4x80

Overview:
Initiator-side controller that drives one srambank_128x4x80_6t122 instance (512 words x 80 bits, synchronous, read data latched in the bank).
- Converts a valid/ready request stream (read or write) into single-cycle bank strobes.
- Captures read data one cycle after issue and returns it through a small response FIFO with valid/ready backpressure.
- Sits between the bank and any client that cannot accept read data on a fixed cycle.

Parameters:
ADDR_W, 9, bank address width (512 words)
DATA_W, 80, data word width
RSP_DEPTH, 2, response FIFO entries (min 2); also the cap on outstanding reads

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read data available
rsp_ready  in  1  client consumes read data
rsp_rdata  out  DATA_W  read data, in request order
sram_address  out  ADDR_W  to bank ADDRESS
sram_wd  out  DATA_W  to bank wd
sram_banksel  out  1  to bank banksel
sram_read  out  1  to bank read
sram_write  out  1  to bank write
sram_dataout  in  DATA_W  from bank dataout
init_done  out  1  only present with SRAM_CTRL_INIT_EN

Behaviour:
- Reset: asynchronous on rst_n low. Clears rd_pending, FIFO pointers and count, and the init counter. rsp_valid=0, rsp_rdata=0, init_done=0. All sram_* strobes are 0 while in reset.
- Accept: a request is accepted when req_valid & req_ready.
- Ready condition: req_ready = !init_busy & (rd_pending + fifo_count - pop < RSP_DEPTH), where pop = rsp_valid & rsp_ready. The combinational rsp_ready->req_ready path is intentional and gives full throughput. Writes are gated by the same condition (conservative).
- Strobes: combinational in the accept cycle.
  - sram_banksel = accept.
  - sram_write = accept & req_write.
  - sram_read = accept & !req_write.
  - sram_address = req_addr; sram_wd = req_wdata.
  - Read and write are never asserted together.
- Read pipeline:
  - Read accepted in cycle N: the bank latches at edge N, and rd_pending=1 during N+1.
  - In N+1, sram_dataout is pushed into the FIFO at the edge ending N+1.
  - rsp_valid rises in N+2. Read-to-response latency is 2 cycles.
  - A write issued in N+1 does not disturb the capture, because the bank holds dataout on writes.
- FIFO: circular, pointer wrap at RSP_DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - rsp_rdata/rsp_valid come from the head register.
  - The credit rule guarantees a push never hits a full FIFO. Overflow is an assertion failure.
- Backpressure: with rsp_ready=0, at most RSP_DEPTH reads are outstanding, then req_ready=0. Writes stall too.
- Ordering: responses are returned strictly in read-issue order. Writes produce no response.
- Reset mid-operation: in-flight reads and buffered responses are discarded and the client must reissue them. Bank contents are untouched (without INIT_EN).

Optional Feature:
SRAM_CTRL_INIT_EN
- Defined: after reset release, a sequencer writes 0 to addresses 0..511, one per cycle (sram_banksel=1, sram_write=1, sram_wd=0, sram_address=counter).
  - init_busy=1 and req_ready=0 throughout.
  - init_done rises the cycle after address 511 is written (cycle 512 after reset release) and stays 1 until the next reset.
  - Reset during init restarts the sequence at address 0.
- Undefined: init_busy is tied 0, the init_done port is absent, and req_ready may go high in the first cycle after reset.

Decomposition:
- Package srambank_pkg:
  - Constants: ADDR_W=9, DATA_W=80, SRAM_WORDS=512.
  - Typedefs: addr_t, data_t, and a req_t struct {write, addr, wdata}.
- One natural sub-module: srambank_rsp_fifo (parameterised depth/width FIFO with push, pop, count and head data).
- The controller top holds the accept logic, rd_pending and the init sequencer.

Test Plan:
- Write 0xA5..A5 to addr 3, then read addr 3 with rsp_ready=1 -> sram_write pulse, then sram_read pulse; rsp_valid 2 cycles after the read accept, rsp_rdata=0xA5..A5.
- 8 back-to-back reads of addrs 0..7 (distinct data preloaded), rsp_ready=1 -> req_ready stays 1; 8 consecutive rsp_valid cycles, data in address order.
- rsp_ready=0, issue 4 reads -> 2 accepted, then req_ready=0. Raise rsp_ready -> 2 responses in order, remaining reads accepted.
- Read addr 5, then write addr 5 in the next cycle -> response carries the old addr-5 data, not the new write data.
- rst_n low for 1 cycle while one read is pending and one response is buffered -> rsp_valid=0 immediately, no stale response after release.
- With SRAM_CTRL_INIT_EN: release reset -> req_ready=0 for 512 cycles, init_done=1 at cycle 512; a read of addr 511 then returns 0.
